// File: rtl/soc_pkg.sv
// soc_pkg - shared bus widths and slave FSM state encoding for the SoC data memory.
// Rev 1.0
`default_nettype none

package soc_pkg;
   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;
endpackage

`default_nettype wire

// File: rtl/soc_dmem_ram.sv
// soc_dmem_ram - synchronous single-port RAM, byte-enable write, write-first read.
// Rev 1.0
`default_nettype none

module soc_dmem_ram
   import soc_pkg::*;
#(
   parameter int NUM_WORDS = 8192,
   localparam int IDX_W    = $clog2(NUM_WORDS)
) (
   input  logic              clk,
   input  logic              i_en,
   input  logic [BE_W-1:0]   i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_wdat,
   output logic [DATA_W-1:0] o_rdat
);
   logic [DATA_W-1:0] r_mem [NUM_WORDS];
   logic [DATA_W-1:0] r_rdat;
   logic [DATA_W-1:0] w_old;
   logic [DATA_W-1:0] w_new;

   assign w_old = r_mem[i_idx];

   // Merged word doubles as the read value, giving new data on read-during-write.
   for (genvar b = 0; b < BE_W; b++) begin : g_lane
      assign w_new[b*8 +: 8] = i_we[b] ? i_wdat[b*8 +: 8] : w_old[b*8 +: 8];
   end

   always_ff @(posedge clk) begin
      if (i_en) begin
         if (|i_we) begin
            r_mem[i_idx] <= w_new;
         end
         r_rdat <= w_new;
      end
   end

   assign o_rdat = r_rdat;
endmodule

`default_nettype wire

// File: rtl/soc_dmem_slv.sv
// soc_dmem_slv - valid/ready data-memory slave with programmable read/write wait states.
// Rev 1.0
`default_nettype none

module soc_dmem_slv
   import soc_pkg::*;
#(
   parameter int NUM_WORDS = 8192,
   parameter int RD_WAIT   = 1,
   parameter int WR_WAIT   = 0
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              vld,
   input  logic [BE_W-1:0]   we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdat,
   output logic              rdy,
   output logic [DATA_W-1:0] rdat
);
   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam logic [CNT_W-1:0] c_RD_CNT = CNT_W'(RD_WAIT);
   localparam logic [CNT_W-1:0] c_WR_CNT = CNT_W'(WR_WAIT);

   dmem_state_t       r_state;
   dmem_state_t       w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  w_load_cnt;
   logic [BE_W-1:0]   r_we;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_wdat;
   logic              r_rdy;
   logic              w_cap;
   logic              w_go;
   logic              w_ram_en;
   logic [BE_W-1:0]   w_ram_we;
   logic [IDX_W-1:0]  w_ram_idx;
   logic [DATA_W-1:0] w_ram_wdat;
   logic [DATA_W-1:0] w_ram_rdat;
   logic              w_unused;

   assign w_unused   = ^addr[ADDR_W-1:IDX_W];
   assign w_load_cnt = (|we) ? c_WR_CNT : c_RD_CNT;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cap       = 1'b0;
      w_go        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (vld) begin
               w_cap     = 1'b1;
               w_cnt_nxt = w_load_cnt;
               if (w_load_cnt == '0) begin
                  w_state_nxt = RESP;
                  w_go        = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = RESP;
               w_go        = 1'b1;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // A zero-wait access hits the RAM on the capture edge, so IDLE routes the live request.
   assign w_ram_we   = (r_state == IDLE) ? we                : r_we;
   assign w_ram_idx  = (r_state == IDLE) ? addr[IDX_W-1:0]   : r_idx;
   assign w_ram_wdat = (r_state == IDLE) ? wdat              : r_wdat;
   assign w_ram_en   = w_go & ~arst;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_we    <= '0;
         r_idx   <= '0;
         r_wdat  <= '0;
         r_rdy   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rdy   <= w_go;
         if (w_cap) begin
            r_we   <= we;
            r_idx  <= addr[IDX_W-1:0];
            r_wdat <= wdat;
         end
      end
   end

   soc_dmem_ram #(
      .NUM_WORDS (NUM_WORDS)
   ) u_ram (
      .clk    (clk),
      .i_en   (w_ram_en),
      .i_we   (w_ram_we),
      .i_idx  (w_ram_idx),
      .i_wdat (w_ram_wdat),
      .o_rdat (w_ram_rdat)
   );

   assign rdy  = r_rdy;
   assign rdat = r_rdy ? w_ram_rdat : '0;
endmodule

`default_nettype wire

// File: tb/tb_soc_dmem_slv.sv
// tb_soc_dmem_slv - directed self-checking bench for soc_dmem_slv.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_soc_dmem_slv;
   logic        clk = 1'b0;
   logic        arst;
   logic        vld, vld3;
   logic [3:0]  we, we3;
   logic [29:0] addr, addr3;
   logic [31:0] wdat, wdat3;
   logic        rdy, rdy3;
   logic [31:0] rdat, rdat3;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   soc_dmem_slv #(.NUM_WORDS(8192), .RD_WAIT(1), .WR_WAIT(0)) dut (
      .clk(clk), .arst(arst), .vld(vld), .we(we), .addr(addr), .wdat(wdat),
      .rdy(rdy), .rdat(rdat)
   );

   soc_dmem_slv #(.NUM_WORDS(16), .RD_WAIT(3), .WR_WAIT(3)) dut3 (
      .clk(clk), .arst(arst), .vld(vld3), .we(we3), .addr(addr3), .wdat(wdat3),
      .rdy(rdy3), .rdat(rdat3)
   );

   // Issues one request (vld held until rdy), returns the response cycle count after acceptance.
   task automatic xfer(input bit sel, input logic [3:0] t_we, input logic [29:0] t_addr,
                       input logic [31:0] t_wdat, output logic [31:0] t_rdat, output int t_lat);
      @(negedge clk);
      if (sel) begin vld3 = 1'b1; we3 = t_we; addr3 = t_addr; wdat3 = t_wdat; end
      else     begin vld  = 1'b1; we  = t_we; addr  = t_addr; wdat  = t_wdat; end
      @(posedge clk);
      t_lat  = -1;
      t_rdat = '0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if ((sel ? rdy3 : rdy) === 1'b1) begin
            t_lat  = n;
            t_rdat = sel ? rdat3 : rdat;
            break;
         end
      end
      if (sel) vld3 = 1'b0; else vld = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (rdy !== 1'b0)      begin errors++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
      checks++; if (rdat !== 32'h0)    begin errors++; $display("FAIL reset_rdat got=%h exp=0", rdat); end
      checks++; if (rdy3 !== 1'b0)     begin errors++; $display("FAIL reset_rdy3 got=%b exp=0", rdy3); end
      checks++; if (rdat3 !== 32'h0)   begin errors++; $display("FAIL reset_rdat3 got=%h exp=0", rdat3); end
      arst = 1'b0;
   endtask

   task automatic test_write_read();
      logic [31:0] d; int lat;
      xfer(1'b0, 4'hF, 30'h10, 32'hA5A5_1234, d, lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL wr_latency got=%0d exp=1", lat); end
      xfer(1'b0, 4'h0, 30'h10, 32'h0, d, lat);
      checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", lat); end
      checks++; if (d !== 32'hA5A5_1234) begin errors++; $display("FAIL rd_data got=%h exp=a5a51234", d); end
      @(negedge clk);
      checks++; if (rdy !== 1'b0)   begin errors++; $display("FAIL rdy_single_cycle got=%b exp=0", rdy); end
      checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL rdat_idle_zero got=%h exp=0", rdat); end
   endtask

   task automatic test_byte_enable();
      logic [31:0] d; int lat;
      xfer(1'b0, 4'hF, 30'h40, 32'hFFFF_FFFF, d, lat);
      xfer(1'b0, 4'h5, 30'h40, 32'h0000_0000, d, lat);
      xfer(1'b0, 4'h0, 30'h40, 32'h0, d, lat);
      checks++; if (d !== 32'hFF00_FF00) begin errors++; $display("FAIL be_0x5 got=%h exp=ff00ff00", d); end
      xfer(1'b0, 4'hA, 30'h40, 32'h1234_5678, d, lat);
      xfer(1'b0, 4'h0, 30'h40, 32'h0, d, lat);
      checks++; if (d !== 32'h1200_5600) begin errors++; $display("FAIL be_0xA got=%h exp=12005600", d); end
   endtask

   task automatic test_alias();
      logic [31:0] d; int lat;
      xfer(1'b0, 4'hF, 30'h0000_2003, 32'h0000_0001, d, lat);
      xfer(1'b0, 4'h0, 30'h0000_0003, 32'h0, d, lat);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL alias_low got=%h exp=1", d); end
      xfer(1'b0, 4'h0, 30'h3FFF_E003, 32'h0, d, lat);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL alias_high got=%h exp=1", d); end
   endtask

   task automatic test_back_to_back();
      int cnt = 0, first = -1, last = -1, bad_sp = 0, bad_z = 0, bad_d = 0;
      @(negedge clk);
      vld = 1'b1; we = 4'h0; addr = 30'h10;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         if (rdy === 1'b1) begin
            cnt++;
            if (first < 0) first = n;
            if (last >= 0 && n - last != 3) bad_sp++;
            last = n;
            if (rdat !== 32'hA5A5_1234) bad_d++;
            if (cnt == 4) vld = 1'b0;
         end else if (rdat !== 32'h0) begin
            bad_z++;
         end
      end
      vld = 1'b0;
      checks++; if (cnt != 4)    begin errors++; $display("FAIL b2b_pulses got=%0d exp=4", cnt); end
      checks++; if (first != 2)  begin errors++; $display("FAIL b2b_first got=%0d exp=2", first); end
      checks++; if (bad_sp != 0) begin errors++; $display("FAIL b2b_spacing got=%0d bad exp=0", bad_sp); end
      checks++; if (bad_z != 0)  begin errors++; $display("FAIL b2b_rdat_zero got=%0d bad exp=0", bad_z); end
      checks++; if (bad_d != 0)  begin errors++; $display("FAIL b2b_rdat got=%0d bad exp=0", bad_d); end
   endtask

   task automatic test_capture();
      logic [31:0] d; int lat;
      xfer(1'b0, 4'hF, 30'h21, 32'h5555_5555, d, lat);
      @(negedge clk);
      vld = 1'b1; we = 4'hF; addr = 30'h20; wdat = 32'h1111_2222;
      @(posedge clk); #1;
      addr = 30'h21; wdat = 32'hDEAD_BEEF;
      for (int n = 0; n < 10 && rdy !== 1'b1; n++) @(negedge clk);
      vld = 1'b0;
      xfer(1'b0, 4'h0, 30'h20, 32'h0, d, lat);
      checks++; if (d !== 32'h1111_2222) begin errors++; $display("FAIL cap_wr_addr got=%h exp=11112222", d); end
      xfer(1'b0, 4'h0, 30'h21, 32'h0, d, lat);
      checks++; if (d !== 32'h5555_5555) begin errors++; $display("FAIL cap_wr_other got=%h exp=55555555", d); end
      @(negedge clk);
      vld = 1'b1; we = 4'h0; addr = 30'h20;
      @(posedge clk); #1;
      addr = 30'h21; we = 4'hF;
      d = '0; lat = -1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (rdy === 1'b1) begin d = rdat; lat = n; break; end
      end
      vld = 1'b0;
      checks++; if (lat != 2) begin errors++; $display("FAIL cap_rd_latency got=%0d exp=2", lat); end
      checks++; if (d !== 32'h1111_2222) begin errors++; $display("FAIL cap_rd_data got=%h exp=11112222", d); end
   endtask

   task automatic test_vld_drop();
      logic [31:0] d; int lat = -1;
      @(negedge clk);
      vld3 = 1'b1; we3 = 4'hF; addr3 = 30'h5; wdat3 = 32'hCAFE_F00D;
      @(posedge clk); #1;
      vld3 = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (rdy3 === 1'b1) begin lat = n; break; end
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL drop_latency got=%0d exp=4", lat); end
      xfer(1'b1, 4'h0, 30'h5, 32'h0, d, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL w3_rd_latency got=%0d exp=4", lat); end
      checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL drop_commit got=%h exp=cafef00d", d); end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] d; int lat; int pulses = 0;
      @(negedge clk);
      vld3 = 1'b1; we3 = 4'hF; addr3 = 30'h5; wdat3 = 32'h0BAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      arst = 1'b1; vld3 = 1'b0;
      for (int n = 0; n < 3; n++) begin @(negedge clk); if (rdy3 !== 1'b0) pulses++; end
      checks++; if (rdat3 !== 32'h0) begin errors++; $display("FAIL rst_wait_rdat got=%h exp=0", rdat3); end
      arst = 1'b0;
      for (int n = 0; n < 6; n++) begin @(negedge clk); if (rdy3 !== 1'b0) pulses++; end
      checks++; if (pulses != 0) begin errors++; $display("FAIL rst_wait_rdy got=%0d pulses exp=0", pulses); end
      xfer(1'b1, 4'h0, 30'h5, 32'h0, d, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL rst_after_latency got=%0d exp=4", lat); end
      checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_wait_nowrite got=%h exp=cafef00d", d); end
   endtask

   initial begin
      arst = 1'b1;
      vld = 1'b0; we = '0; addr = '0; wdat = '0;
      vld3 = 1'b0; we3 = '0; addr3 = '0; wdat3 = '0;
      test_reset();
      test_write_read();
      test_byte_enable();
      test_alias();
      test_back_to_back();
      test_capture();
      test_vld_drop();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
